// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional BRPRED_STATS_EN adds branch and mispredict event counters.
module branch_target_predictor #(
  parameter int unsigned IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredPCF,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredPCE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE
`ifdef BRPRED_STATS_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
`endif
);

  localparam int unsigned N     = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [N-1:0]            valid_q;
  logic [N-1:0][1:0]       ctr_q;
  logic [TAG_W-1:0]        tag_q    [N];
  logic [31:0]             target_q [N];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             is_br, upd, alloc, train, wr_target;
  logic [1:0]       ctr_cur, ctr_nxt;
  logic             unused_pc_bits;

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Fetch-side lookup; reads pre-update contents, no bypass from EX write
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTakenF  = rst_n && f_hit && ctr_q[f_idx][1];
  assign PredPCF     = PredTakenF ? target_q[f_idx] : PCF + 32'd4;

  assign e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign is_br       = (BranchTypeE != 3'd0);
  assign upd         = is_br && !StallE;

  assign MispredictE = rst_n && is_br &&
                       ((PredTakenE != BranchE) ||
                        (PredTakenE && BranchE && (PredPCE != BrTargetE)));
  assign RedirectPCE = BranchE ? BrTargetE : PCE + 32'd4;

  // Training decisions for the EX-indexed entry
  always_comb begin
    alloc     = 1'b0;
    train     = 1'b0;
    wr_target = 1'b0;
    ctr_cur   = ctr_q[e_idx];
    ctr_nxt   = ctr_cur;
    if (upd) begin
      if (e_hit) begin
        train     = 1'b1;
        wr_target = BranchE;
        if (BranchE) ctr_nxt = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
        else         ctr_nxt = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;
      end else if (BranchE) begin
        alloc     = 1'b1;
        wr_target = 1'b1;
        ctr_nxt   = 2'b10;
      end
    end
  end

  // Valid bits and counters are reset so training is discarded at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ctr_q   <= {N{2'b01}};
    end else begin
      if (alloc) valid_q[e_idx] <= 1'b1;
      if (alloc || train) ctr_q[e_idx] <= ctr_nxt;
    end
  end

  // Tag and target are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    if (alloc)     tag_q[e_idx]    <= e_tag;
    if (wr_target) target_q[e_idx] <= BrTargetE;
  end

`ifdef BRPRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else if (upd) begin
      BrCount <= BrCount + 32'd1;
      if (MispredictE) MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule
